// File: rtl/button_conditioner.sv
// button_conditioner: turns raw, asynchronous push-button inputs into clean
// debounced levels plus single-cycle press/release event pulses.
// Each button gets its own 2-FF synchroniser, debounce counter and edge pulses.
// Optional build macro BUTTON_CONDITIONER_AUTO_REPEAT_EN adds hold-to-repeat
// pulses on btn_repeat; without it btn_repeat is tied low and no hold counters
// exist. The port list is the same in both builds.
module button_conditioner #(
  parameter int N_BTN         = 7,
  parameter int DB_CYCLES     = 2_000_000,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             enable,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_press
);

  // Debounce counter only ever needs to reach DB_CYCLES-1.
  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  // One hold counter serves both the initial hold delay and the repeat period.
  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
`else
  // Repeat timing only matters when auto-repeat is built in.
  logic w_unused_cfg;
  assign w_unused_cfg = HOLD_CYCLES[0] ^ REPEAT_CYCLES[0];
  assign btn_repeat   = '0;
`endif

  logic [N_BTN-1:0] w_press_next;
  logic             r_any;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic            r_sync1;
      logic            r_sync2;
      logic            r_stable;
      logic [DB_W-1:0] r_db_cnt;
      logic            r_press;
      logic            r_release;
      logic            w_differ;
      logic            w_db_done;
      logic            w_rise;
      logic            w_fall;

      assign w_differ  = r_sync2 ^ r_stable;
      assign w_db_done = w_differ && (r_db_cnt == DB_LAST);
      assign w_rise    = w_db_done && r_sync2;
      assign w_fall    = w_db_done && !r_sync2;

      // Two-flop synchroniser for the asynchronous raw input
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
        end else begin
          r_sync1 <= btn_raw[gi];
          r_sync2 <= r_sync1;
        end
      end

      // Debounce: accept a new level only after DB_CYCLES consecutive differing samples
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_db_cnt <= '0;
          r_stable <= 1'b0;
        end else if (!w_differ) begin
          r_db_cnt <= '0;
        end else if (w_db_done) begin
          r_db_cnt <= '0;
          r_stable <= r_sync2;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end

      // Registered edge pulses, coincident with the level change, masked by enable
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_press   <= w_rise && enable;
          r_release <= w_fall && enable;
        end
      end

      assign w_press_next[gi] = w_rise && enable;
      assign btn_level[gi]    = r_stable;
      assign btn_press[gi]    = r_press;
      assign btn_release[gi]  = r_release;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
      logic [HOLD_W-1:0] r_hold_cnt;
      logic              r_hold_phase;
      logic              r_repeat;
      logic              w_hold_hit;

      // Phase 0 waits for the initial hold delay, phase 1 for each repeat period.
      assign w_hold_hit = r_stable &&
                          (r_hold_cnt == (r_hold_phase ? REP_LAST : HOLD_LAST));

      // Hold timer: runs while held, clears on release (a coincident repeat is dropped)
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_hold_cnt   <= '0;
          r_hold_phase <= 1'b0;
          r_repeat     <= 1'b0;
        end else if (!r_stable || w_fall) begin
          r_hold_cnt   <= '0;
          r_hold_phase <= 1'b0;
          r_repeat     <= 1'b0;
        end else if (w_hold_hit) begin
          r_hold_cnt   <= '0;
          r_hold_phase <= 1'b1;
          r_repeat     <= enable;
        end else begin
          r_hold_cnt   <= r_hold_cnt + 1'b1;
          r_repeat     <= 1'b0;
        end
      end

      assign btn_repeat[gi] = r_repeat;
`endif
    end
  endgenerate

  // any_press is registered alongside the individual press pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |w_press_next;
    end
  end

  assign any_press = r_any;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// button activity, compared each cycle against a sliding-window reference model.
module tb_button_conditioner;
  localparam int N    = 7;
  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;
  logic         any_press;

  int n_vec = 0;
  int n_err = 0;

  button_conditioner #(
    .N_BTN(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .enable(enable),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .any_press(any_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_hist[b][k] = raw value present k edges ago (k=0 is this edge).
  // The debounced view at an edge is raw from two edges earlier, so a level
  // flips when the DB samples seen through the synchroniser all disagree with it.
  bit           m_hist [N][DB+2];
  bit           m_level [N];
  int           m_press_t [N];
  int           cyc = 0;
  logic [N-1:0] e_level, e_press, e_rel, e_rep;
  logic         e_any;

  task automatic model_reset();
    for (int b = 0; b < N; b++) begin
      for (int k = 0; k < DB + 2; k++) m_hist[b][k] = 1'b0;
      m_level[b]   = 1'b0;
      m_press_t[b] = 0;
    end
    e_level = '0; e_press = '0; e_rel = '0; e_rep = '0; e_any = 1'b0;
  endtask

  task automatic model_edge();
    bit all_diff, rise, fall;
    int d;
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    e_press = '0; e_rel = '0; e_rep = '0;
    for (int b = 0; b < N; b++) begin
      for (int k = DB + 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
      m_hist[b][0] = btn_raw[b];
      all_diff = 1'b1;
      for (int k = 2; k < DB + 2; k++)
        if (m_hist[b][k] == m_level[b]) all_diff = 1'b0;
      rise = all_diff && !m_level[b];
      fall = all_diff &&  m_level[b];
      e_press[b] = rise && enable;
      e_rel[b]   = fall && enable;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
      if (m_level[b] && !fall) begin
        d = cyc - m_press_t[b];
        e_rep[b] = enable && ((d == HOLD) || (d > HOLD && ((d - HOLD) % REP) == 0));
      end
`else
      d = 0;
`endif
      if (rise) m_press_t[b] = cyc;
      if (all_diff) m_level[b] = !m_level[b];
      e_level[b] = m_level[b];
    end
    e_any = |e_press;
  endtask

  task automatic compare_all();
    check("level",   btn_level,   e_level);
    check("press",   btn_press,   e_press);
    check("release", btn_release, e_rel);
    check("repeat",  btn_repeat,  e_rep);
    check("any",     any_press,   e_any);
  endtask

  // One clock: model the edge, then sample the DUT 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Count edges until the chosen pulse (0 press, 1 release, 2 repeat) on button b.
  task automatic wait_pulse(input int which, input int b, input int max, output int n);
    bit found = 1'b0;
    n = 0;
    while (!found && n < max) begin
      step();
      n++;
      case (which)
        0:       found = btn_press[b];
        1:       found = btn_release[b];
        default: found = btn_repeat[b];
      endcase
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    int n, cnt;
    int offs[$];
    logic [N-1:0] pair;
    model_reset();

    // 1: reset state
    run(3);
    rst = 1'b0;
    run(4);
    check("reset_level", btn_level, 0);
    $display("scenario 1: reset state checked");

    // 2: single press/release latency and pulse width
    btn_raw[0] = 1'b1;
    wait_pulse(0, 0, 20, n);
    check("press_latency", n, DB + 2);
    check("level0_high", btn_level[0], 1);
    step();
    check("press_width", btn_press[0], 0);
    run(5);
    btn_raw[0] = 1'b0;
    wait_pulse(1, 0, 20, n);
    check("release_latency", n, DB + 2);
    run(4);
    $display("scenario 2: press/release latency %0d", n);

    // 3: glitch rejection with bounce
    foreach (pair[i]) pair[i] = 1'b0;
    begin
      bit pat [9] = '{1, 1, 1, 0, 1, 0, 1, 1, 0};
      for (int i = 0; i < 9; i++) begin
        btn_raw[3] = pat[i];
        step();
      end
    end
    run(10);
    check("bounce_level3", btn_level[3], 0);
    $display("scenario 3: bounce rejected");

    // 4: simultaneous presses
    btn_raw[1] = 1'b1;
    btn_raw[5] = 1'b1;
    wait_pulse(0, 1, 20, n);
    pair = btn_press;
    check("pair_press", pair, 7'b0100010);
    check("pair_any", any_press, 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (any_press) cnt++;
    end
    check("pair_any_once", cnt, 0);
    btn_raw[1] = 1'b0;
    btn_raw[5] = 1'b0;
    run(10);
    $display("scenario 4: simultaneous press %b", pair);

    // 5: enable masking
    enable = 1'b0;
    btn_raw[2] = 1'b1;
    run(10);
    check("masked_level2", btn_level[2], 1);
    enable = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (btn_press[2]) cnt++;
    end
    check("no_late_press", cnt, 0);
    btn_raw[2] = 1'b0;
    wait_pulse(1, 2, 20, n);
    check("enabled_release", n, DB + 2);
    run(4);
    $display("scenario 5: enable masking checked");

    // reset while held, then fresh press once rst falls
    btn_raw[6] = 1'b1;
    wait_pulse(0, 6, 20, n);
    run(3);
    do_reset();
    check("rst_cleared_level6", btn_level[6], 0);
    wait_pulse(0, 6, 20, n);
    check("press_after_rst", n, DB + 2);
    btn_raw[6] = 1'b0;
    run(10);
    $display("scenario reset-mid-press: fresh press after %0d edges", n);

    // 6: auto-repeat
    btn_raw[4] = 1'b1;
    wait_pulse(0, 4, 20, n);
    for (int d = 1; d <= 44; d++) begin
      step();
      if (btn_repeat[4]) offs.push_back(d);
    end
    btn_raw[4] = 1'b0;
    n = 44;
    while (btn_level[4] && n < 70) begin
      step();
      n++;
      if (btn_repeat[4]) offs.push_back(n);
    end
    check("hold_release_at", n, 50);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    check("repeat_count", offs.size(), 4);
    for (int i = 0; i < 4 && i < offs.size(); i++)
      check("repeat_offset", offs[i], HOLD + i * REP);
`else
    check("repeat_count", offs.size(), 0);
`endif
    run(10);
    $display("scenario 6: %0d repeat pulses", offs.size());

    // random activity: fast-bouncing and slow buttons, enable flips, resets
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 99) < ((b < 3) ? 20 : 2)) btn_raw[b] = ~btn_raw[b];
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if ($urandom_range(0, 699) == 0) do_reset();
      step();
    end
    $display("random phase: 3000 cycles applied");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
